// File: rtl/lfsr_arbiter_ctrl.sv
// lfsr_arbiter_ctrl: two requesters compete round-robin for a single LFSR
// generator. An accepted job streams `count` successive LFSR states out through
// a valid/ready port. After the last word there is at least one IDLE cycle
// before the next job can be accepted.
//
// Handshake rule (both the requester ports and the output port): a transfer
// happens on a rising clk edge where valid && ready are both high. A valid
// output is held stable until it transfers. out_valid does not depend
// combinationally on out_ready.
module lfsr_arbiter_ctrl #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_taps,
    input  logic [WIDTH-1:0] req1_taps,
    input  logic [WIDTH-1:0] req0_seed,
    input  logic [WIDTH-1:0] req1_seed,
    input  logic [CNT_W-1:0] req0_count,
    input  logic [CNT_W-1:0] req1_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_owner,
    output logic             out_last,
    output logic             busy,
    output logic             seed_fixed,
    output logic             fsm_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] taps_q;
    logic [CNT_W-1:0] remaining_q;
    logic             owner_q;
    logic             last_owner_q;
    logic             seed_fixed_q;

    logic             grant_valid;
    logic             grant_idx;
    logic [WIDTH-1:0] sel_taps;
    logic [WIDTH-1:0] sel_seed;
    logic [CNT_W-1:0] sel_count;
    logic             accept;
    logic             transfer;
    logic             last_word;

    // Round-robin grant: on contention the requester that did not win last time goes first.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_valid = 1'b1;
            grant_idx   = ~last_owner_q;
        end else if (req0_valid) begin
            grant_valid = 1'b1;
            grant_idx   = 1'b0;
        end else if (req1_valid) begin
            grant_valid = 1'b1;
            grant_idx   = 1'b1;
        end
    end

    // Route the granted requester's job fields to the capture registers.
    always_comb begin
        sel_taps  = grant_idx ? req1_taps  : req0_taps;
        sel_seed  = grant_idx ? req1_seed  : req0_seed;
        sel_count = grant_idx ? req1_count : req0_count;
    end

    // Readys are gated by reset so both stay low while reset is held.
    assign accept     = reset && (state_q == IDLE) && grant_valid;
    assign req0_ready = accept && !grant_idx;
    assign req1_ready = accept && grant_idx;
    assign transfer   = (state_q == RUN) && out_ready;
    assign last_word  = (remaining_q == CNT_W'(1));

    // Next-state logic: a zero-count job is consumed without leaving IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && (sel_count != '0)) state_d = RUN;
            RUN:  if (transfer && last_word)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Job capture on acceptance and LFSR/counter advance on each output transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q       <= '0;
            taps_q       <= '0;
            remaining_q  <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            seed_fixed_q <= 1'b0;
        end else if (accept) begin
            taps_q       <= sel_taps;
            lfsr_q       <= (sel_seed == '0) ? WIDTH'(1) : sel_seed;
            remaining_q  <= sel_count;
            owner_q      <= grant_idx;
            last_owner_q <= grant_idx;
            if (sel_seed == '0) seed_fixed_q <= 1'b1;
        end else if (transfer) begin
            lfsr_q      <= {lfsr_q[WIDTH-2:0], ^(lfsr_q & taps_q)};
            remaining_q <= remaining_q - CNT_W'(1);
        end
    end

    // Output fields are forced to zero whenever no word is valid.
    assign out_valid  = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign out_data   = out_valid ? lfsr_q : '0;
    assign out_owner  = out_valid && owner_q;
    assign out_last   = out_valid && last_word;
    assign seed_fixed = seed_fixed_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_lfsr_arbiter_ctrl.sv
// Bench for lfsr_arbiter_ctrl. A job-level model precomputes the complete word
// list of every accepted job into a queue. A per-cycle compare then checks all
// DUT outputs against the head of that queue and against the arbitration rules.
module tb_lfsr_arbiter_ctrl;
  localparam int W  = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_taps, req1_taps, req0_seed, req1_seed;
  logic [CW-1:0] req0_count, req1_count;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_data;
  logic          out_owner, out_last, busy, seed_fixed, fsm_state;

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic [W-1:0] exp_q[$];
  logic         m_owner, m_last_owner, m_fixed;
  // transfer logs for literal checks
  logic [W-1:0] got_q[$];
  logic         got_own[$];
  logic [W-1:0] exp_lit[$];
  logic         own_lit[$];

  lfsr_arbiter_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_taps(req0_taps), .req1_taps(req1_taps),
    .req0_seed(req0_seed), .req1_seed(req1_seed),
    .req0_count(req0_count), .req1_count(req1_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_owner(out_owner), .out_last(out_last),
    .busy(busy), .seed_fixed(seed_fixed), .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s, input logic [W-1:0] t);
    int p = 0;
    for (int i = 0; i < W; i++) p ^= int'(s[i] & t[i]);
    return W'((int'(s) * 2 + p) % (1 << W));
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_owner = 1'b0;
    m_last_owner = 1'b1;
    m_fixed = 1'b0;
  endtask

  // One cycle: called at a negedge with inputs already driven; checks, then
  // advances the model to match the coming posedge.
  task automatic step();
    logic m_busy, gv, gi;
    logic [W-1:0] t, s;
    logic [CW-1:0] c;
    #1;
    m_busy = (exp_q.size() != 0);
    gv = 1'b0; gi = 1'b0;
    if (!m_busy) begin
      if (req0_valid && req1_valid) begin gv = 1'b1; gi = !m_last_owner; end
      else if (req0_valid) begin gv = 1'b1; gi = 1'b0; end
      else if (req1_valid) begin gv = 1'b1; gi = 1'b1; end
    end
    check("out_valid", out_valid, m_busy);
    check("busy", busy, m_busy);
    check("fsm_state", fsm_state, m_busy);
    check("out_data", out_data, m_busy ? exp_q[0] : '0);
    check("out_last", out_last, m_busy && exp_q.size() == 1);
    check("out_owner", out_owner, m_busy && m_owner);
    check("req0_ready", req0_ready, gv && !gi);
    check("req1_ready", req1_ready, gv && gi);
    check("seed_fixed", seed_fixed, m_fixed);
    if (m_busy) begin
      if (out_ready) begin
        got_q.push_back(out_data);
        got_own.push_back(out_owner);
        void'(exp_q.pop_front());
      end
    end else if (gv) begin
      t = gi ? req1_taps  : req0_taps;
      s = gi ? req1_seed  : req0_seed;
      c = gi ? req1_count : req0_count;
      if (s == '0) begin s = W'(1); m_fixed = 1'b1; end
      m_last_owner = gi;
      if (c != '0) begin
        m_owner = gi;
        for (int i = 0; i < int'(c); i++) begin
          exp_q.push_back(s);
          s = lfsr_next(s, t);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin step(); n++; end
    check("job_done_in_budget", exp_q.size(), 0);
    step();
  endtask

  task automatic drive_req(input int idx, input logic v, input logic [W-1:0] t,
                           input logic [W-1:0] s, input logic [CW-1:0] c);
    if (idx == 0) begin req0_valid = v; req0_taps = t; req0_seed = s; req0_count = c; end
    else          begin req1_valid = v; req1_taps = t; req1_seed = s; req1_count = c; end
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, got_q.size(), exp_lit.size());
    for (int i = 0; i < exp_lit.size() && i < got_q.size(); i++)
      check(name, got_q[i], exp_lit[i]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_owner", out_owner, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_seed_fixed", seed_fixed, 0);
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    model_reset();
    got_q.delete();
    got_own.delete();
  endtask

  initial begin
    reset = 1'b0;
    out_ready = 1'b1;
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    model_reset();
    @(negedge clk);
    do_reset();

    // reference 7-word sequence, taps 101 seed 001
    drive_req(0, 1'b1, 3'b101, 3'b001, 8'd7);
    step();
    req0_valid = 1'b0;
    run_until_idle(20);
    exp_lit = '{3'd1, 3'd3, 3'd7, 3'd6, 3'd5, 3'd2, 3'd4};
    check_log("seq7");
    own_lit = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < got_own.size() && i < own_lit.size(); i++)
      check("seq7_owner", got_own[i], own_lit[i]);

    // alternation with both requesters permanently valid
    do_reset();
    drive_req(0, 1'b1, 3'b101, 3'b001, 8'd2);
    drive_req(1, 1'b1, 3'b011, 3'b100, 8'd2);
    for (int i = 0; i < 9; i++) step();
    own_lit = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    check("alt_len", got_own.size(), own_lit.size());
    for (int i = 0; i < got_own.size() && i < own_lit.size(); i++)
      check("alt_owner", got_own[i], own_lit[i]);
    req0_valid = 1'b0; req1_valid = 1'b0;
    run_until_idle(10);

    // zero seed replacement
    do_reset();
    drive_req(1, 1'b1, 3'b101, 3'b000, 8'd3);
    step();
    req1_valid = 1'b0;
    run_until_idle(10);
    exp_lit = '{3'd1, 3'd3, 3'd7};
    check_log("zseed");
    check("zseed_flag", seed_fixed, 1);

    // backpressure pattern 1,0,0
    do_reset();
    drive_req(0, 1'b1, 3'b101, 3'b001, 8'd5);
    step();
    req0_valid = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      out_ready = (i % 3 == 0);
      step();
    end
    out_ready = 1'b1;
    run_until_idle(5);
    exp_lit = '{3'd1, 3'd3, 3'd7, 3'd6, 3'd5};
    check_log("stall");

    // zero count, then contention goes to req1
    do_reset();
    drive_req(0, 1'b1, 3'b101, 3'b011, 8'd0);
    step();
    drive_req(0, 1'b1, 3'b101, 3'b011, 8'd1);
    drive_req(1, 1'b1, 3'b110, 3'b010, 8'd1);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    run_until_idle(5);
    check("zcnt_len", got_own.size(), 1);
    if (got_own.size() > 0) check("zcnt_owner", got_own[0], 1);

    // reset in the middle of a job
    do_reset();
    drive_req(0, 1'b1, 3'b101, 3'b001, 8'd7);
    step();
    req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_busy", busy, 0);
    check("abort_out_last", out_last, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    got_q.delete();
    drive_req(1, 1'b1, 3'b011, 3'b110, 8'd3);
    step();
    req1_valid = 1'b0;
    run_until_idle(10);
    exp_lit = '{3'd6, 3'd5, 3'd3};
    check_log("after_abort");

    // maximum count runs to completion
    do_reset();
    drive_req(0, 1'b1, 3'b110, 3'b101, 8'd255);
    step();
    req0_valid = 1'b0;
    run_until_idle(300);
    check("maxcnt_words", got_q.size(), 255);

    // randomized traffic, inputs change freely while a job runs
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive_req(0, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom), CW'($urandom_range(0, 5)));
      drive_req(1, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom), CW'($urandom_range(0, 5)));
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    run_until_idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lfsr_arbiter_ctrl.md
LFSR_ARBITER_CTRL -- requirements
Module: lfsr_arbiter_ctrl

Interface
REQ-001 Parameter: WIDTH, default 3, LFSR state/tap/seed width; legal range 2..32.
REQ-002 Parameter: CNT_W, default 8, width of the per-job word count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately, independent of clk.
REQ-005 req0_valid / req1_valid  input  1 each  requester N presents a job.
REQ-006 req0_ready / req1_ready  output  1 each  job from requester N accepted when valid&&ready are both high at a clk edge.
REQ-007 req0_taps / req1_taps  input  WIDTH each  tap mask for the job.
REQ-008 req0_seed / req1_seed  input  WIDTH each  initial LFSR state for the job.
REQ-009 req0_count / req1_count  input  CNT_W each  number of output words requested.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_ready  input  1  downstream accepts the word; transfer = out_valid&&out_ready.
REQ-012 out_data  output  WIDTH  current LFSR state of the running job.
REQ-013 out_owner  output  1  index of the requester that owns the running job.
REQ-014 out_last  output  1  high with the final word of a job.
REQ-015 busy  output  1  high in RUN state.
REQ-016 seed_fixed  output  1  sticky; set when a zero seed was replaced; cleared only by reset.

Function
REQ-017 FSM states: IDLE, RUN; no other states.
REQ-018 IDLE grant: combinational round-robin; if only one reqN_valid, grant N; if both valid, grant the requester not equal to last_owner; if none valid, no grant.
REQ-019 reqN_ready = (state==IDLE) && (grant==N); both readys never high together; both low in RUN.
REQ-020 On acceptance: capture taps, seed, count, owner; last_owner <= granted index.
REQ-021 Zero seed: captured state = 1 (LSB set) and seed_fixed <= 1; non-zero seed captured unchanged.
REQ-022 Zero count: job accepted, no output word produced, FSM stays IDLE, last_owner still updates.
REQ-023 Non-zero count: FSM -> RUN on the accepting edge; out_valid high the next cycle (latency 1 clk); first out_data = captured seed.
REQ-024 RUN: out_valid=1 continuously; out_data, out_owner, out_last held stable while out_ready=0 (backpressure, no state change).
REQ-025 On each transfer: state <= {state[WIDTH-2:0], ^(state & taps)}; remaining <= remaining-1.
REQ-026 out_last = (remaining==1) in RUN; transfer with out_last high -> IDLE, out_valid low next cycle.
REQ-027 New job cannot be accepted in the cycle the last word transfers; earliest acceptance is the following cycle (one IDLE cycle minimum between jobs).
REQ-028 Requester inputs are ignored in RUN; changes to taps/seed/count after acceptance have no effect on the running job.
REQ-029 out_data, out_owner, out_last are 0 whenever out_valid=0.
REQ-030 count = 2^CNT_W-1 runs to completion without wrap; remaining never underflows.

Reset
REQ-031 reset=0 forces: state=IDLE, LFSR state=0, taps=0, remaining=0, last_owner=1 (requester 0 wins first contention), out_valid=0, out_data=0, out_owner=0, out_last=0, busy=0, req0_ready=req1_ready=0 while reset low, seed_fixed=0.
REQ-032 Reset asserted in RUN aborts the job immediately; no further words; after release the FSM starts in IDLE with the round-robin pointer reinitialised.

Verification (WIDTH=3, CNT_W=8)
REQ-033 req0 taps=101 seed=001 count=7, out_ready=1 -> out_data 001,011,111,110,101,010,100 on consecutive cycles, out_owner=0, out_last only on 100, then out_valid=0.
REQ-034 Both valid after reset, each count=2 -> req0 served first, then req1; with both still valid afterwards, req0 served next (alternation).
REQ-035 req1 seed=000 taps=101 count=3 -> seed_fixed=1, out_data 001,011,111.
REQ-036 count=5, out_ready toggling 1,0,0,1,... -> each word held while stalled; exactly 5 transfers, sequence identical to the out_ready=1 case.
REQ-037 req0 count=0 -> req0_ready pulses once, out_valid stays 0, next contention grants req1.
REQ-038 reset driven low mid-job after 3rd word -> all outputs 0 asynchronously; after release, new job starts from its own seed.
